fetch_pc_stage: RTL and testbench

Program-counter and fetch stage that consumes the 12-bit next-PC value chosen by the next-PC select mux, and produces the PC+1 value that feeds that mux's sequential input. Holds the PC register and drives the synchronous instruction memory (one-cycle read latency). Presents a fetch/decode output latch to decode and supports stall, via a skid register for the in-flight instruction, and flush, via bubble insertion.

---
 rtl/fetch_pc_stage_pkg.sv | 10 +
 rtl/fetch_pc_stage_pc_incr_12.sv | 21 ++
 rtl/fetch_pc_stage.sv | 84 ++++++++
 tb/tb_fetch_pc_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_stage_pkg.sv
// Shared widths and constants for the fetch / PC stage.
package fetch_pc_stage_pkg;

  localparam int PC_W   = 12;
  localparam int INSN_W = 32;

  localparam logic [PC_W-1:0]   RESET_PC = 12'd0;
  localparam logic [INSN_W-1:0] NOP_INSN = '0;

endpackage

// File: rtl/fetch_pc_stage_pc_incr_12.sv
// Ripple-carry +1 incrementer built from explicit half-adder cells; wraps modulo 2^W.
module pc_incr_12 #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] sum
);

  logic [W-1:0] carry;

  assign carry[0] = 1'b1;

  // Each bit is a half adder fed by the carry out of the bit below; the top carry is dropped.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum[i] = a[i] ^ carry[i];
    if (i < W - 1) begin : g_carry
      assign carry[i+1] = a[i] & carry[i];
    end
  end

endmodule

// File: rtl/fetch_pc_stage.sv
// PC register plus fetch/decode latch with stall skid register and flush bubble insertion.
module fetch_pc_stage
  import fetch_pc_stage_pkg::*;
#(
  parameter int                 PC_W     = fetch_pc_stage_pkg::PC_W,
  parameter int                 INSN_W   = fetch_pc_stage_pkg::INSN_W,
  parameter logic [PC_W-1:0]    RESET_PC = fetch_pc_stage_pkg::RESET_PC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PC_W-1:0]   next_pc,
  input  logic              stall,
  input  logic              flush,
  input  logic [INSN_W-1:0] imem_q,
  output logic [PC_W-1:0]   imem_address,
  output logic [PC_W-1:0]   pc_plus1,
  output logic [PC_W-1:0]   fd_pc,
  output logic [PC_W-1:0]   fd_pc_plus1,
  output logic [INSN_W-1:0] fd_insn,
  output logic              fd_valid
);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   f_pc_q, f_pc_d;
  logic              f_valid_q, f_valid_d;
  logic              hold_q, hold_d;
  logic [INSN_W-1:0] hold_insn_q, hold_insn_d;

  pc_incr_12 #(.W(PC_W)) u_pc_incr (
    .a   (pc_q),
    .sum (pc_plus1)
  );

  pc_incr_12 #(.W(PC_W)) u_fd_pc_incr (
    .a   (f_pc_q),
    .sum (fd_pc_plus1)
  );

  assign imem_address = pc_q;
  assign fd_pc        = f_pc_q;
  assign fd_valid     = f_valid_q;
  assign fd_insn      = !f_valid_q ? INSN_W'(NOP_INSN) : (hold_q ? hold_insn_q : imem_q);

  // Flush beats stall; the first stalled edge parks the in-flight word before memory moves on.
  always_comb begin
    pc_d        = pc_q;
    f_pc_d      = f_pc_q;
    f_valid_d   = f_valid_q;
    hold_d      = hold_q;
    hold_insn_d = hold_insn_q;
    if (flush) begin
      pc_d      = next_pc;
      f_valid_d = 1'b0;
      hold_d    = 1'b0;
    end else if (stall) begin
      if (!hold_q) begin
        hold_insn_d = imem_q;
        hold_d      = 1'b1;
      end
    end else begin
      f_pc_d    = pc_q;
      f_valid_d = 1'b1;
      pc_d      = next_pc;
      hold_d    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      f_pc_q      <= '0;
      f_valid_q   <= 1'b0;
      hold_q      <= 1'b0;
      hold_insn_q <= '0;
    end else begin
      pc_q        <= pc_d;
      f_pc_q      <= f_pc_d;
      f_valid_q   <= f_valid_d;
      hold_q      <= hold_d;
      hold_insn_q <= hold_insn_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Self-checking bench: directed scenarios plus random stall/flush/reset against a PC-level model.
module tb_fetch_pc_stage;
  import fetch_pc_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [11:0] next_pc = 12'd0;
  logic [31:0] imem_q;
  logic [11:0] imem_address;
  logic [11:0] pc_plus1;
  logic [11:0] fd_pc;
  logic [11:0] fd_pc_plus1;
  logic [31:0] fd_insn;
  logic        fd_valid;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: architectural PC and the instruction slot shown to decode.
  int m_pc  = 0;
  int m_fpc = 0;
  bit m_fv  = 1'b0;

  fetch_pc_stage dut (
    .clock        (clock),
    .reset        (reset),
    .next_pc      (next_pc),
    .stall        (stall),
    .flush        (flush),
    .imem_q       (imem_q),
    .imem_address (imem_address),
    .pc_plus1     (pc_plus1),
    .fd_pc        (fd_pc),
    .fd_pc_plus1  (fd_pc_plus1),
    .fd_insn      (fd_insn),
    .fd_valid     (fd_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return 32'h1000 + {20'd0, a};
  endfunction

  // Synchronous instruction memory: one-cycle read latency.
  always @(posedge clock) imem_q <= mem_word(imem_address);

  logic [80:0] obs;
  assign obs = {fd_valid, fd_pc, fd_pc_plus1, fd_insn, imem_address, pc_plus1};

  function automatic logic [80:0] expected();
    logic [11:0] fpc, fpc1, pc, pc1;
    logic [31:0] insn;
    fpc  = 12'(m_fpc);
    fpc1 = 12'((m_fpc + 1) % 4096);
    pc   = 12'(m_pc);
    pc1  = 12'((m_pc + 1) % 4096);
    insn = m_fv ? mem_word(fpc) : 32'h0;
    return {m_fv, fpc, fpc1, insn, pc, pc1};
  endfunction

  function automatic logic [11:0] seq_pc();
    return 12'((m_pc + 1) % 4096);
  endfunction

  // Drive one cycle of inputs, advance the model on the edge, then settle past the edge.
  task automatic tick(input logic r, input logic s, input logic f, input logic [11:0] np);
    reset   = r;
    stall   = s;
    flush   = f;
    next_pc = np;
    @(posedge clock);
    if (r) begin
      m_pc  = int'(RESET_PC);
      m_fv  = 1'b0;
      m_fpc = 0;
    end else if (f) begin
      m_pc = int'(np);
      m_fv = 1'b0;
    end else if (!s) begin
      m_fpc = m_pc;
      m_fv  = 1'b1;
      m_pc  = int'(np);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0, 1'b0, 12'h123);
      compared++;
      if (obs !== expected()) begin
        mismatched++;
        $display("[TB] FAIL reset[%0d]: got %h want %h", i, obs, expected());
      end
    end
  endtask

  task automatic test_free_run();
    tick(1'b1, 1'b0, 1'b0, 12'd0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 1'b0, seq_pc());
      compared++;
      if (obs !== expected()) begin
        mismatched++;
        $display("[TB] FAIL free_run[%0d]: got %h want %h", i, obs, expected());
      end
    end
  endtask

  task automatic test_stall();
    tick(1'b1, 1'b0, 1'b0, 12'd0);
    for (int i = 0; i < 20 && !(m_fv && m_fpc == 5); i++) tick(1'b0, 1'b0, 1'b0, seq_pc());
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, 12'(($urandom % 4096)));
      compared++;
      if (obs !== expected() || fd_insn !== 32'h1005 || imem_address !== 12'd6) begin
        mismatched++;
        $display("[TB] FAIL stall_hold[%0d]: got %h want %h", i, obs, expected());
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0, seq_pc());
      compared++;
      if (obs !== expected()) begin
        mismatched++;
        $display("[TB] FAIL stall_release[%0d]: got %h want %h", i, obs, expected());
      end
    end
  endtask

  task automatic test_flush();
    tick(1'b1, 1'b0, 1'b0, 12'd0);
    for (int i = 0; i < 20 && !(m_fv && m_fpc == 7); i++) tick(1'b0, 1'b0, 1'b0, seq_pc());
    tick(1'b0, 1'b0, 1'b1, 12'h200);
    compared++;
    if (obs !== expected() || fd_valid !== 1'b0 || fd_insn !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL flush_bubble: got %h want %h", obs, expected());
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0, seq_pc());
      compared++;
      if (obs !== expected()) begin
        mismatched++;
        $display("[TB] FAIL flush_target[%0d]: got %h want %h", i, obs, expected());
      end
    end
  endtask

  task automatic test_stall_flush();
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0, seq_pc());
    tick(1'b0, 1'b1, 1'b0, seq_pc());
    tick(1'b0, 1'b1, 1'b1, 12'h040);
    compared++;
    if (obs !== expected() || imem_address !== 12'h040) begin
      mismatched++;
      $display("[TB] FAIL stall_flush: got %h want %h", obs, expected());
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0, seq_pc());
      compared++;
      if (obs !== expected()) begin
        mismatched++;
        $display("[TB] FAIL stall_flush_after[%0d]: got %h want %h", i, obs, expected());
      end
    end
  endtask

  task automatic test_wrap();
    tick(1'b0, 1'b0, 1'b1, 12'hFFD);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 1'b0, seq_pc());
      compared++;
      if (obs !== expected()) begin
        mismatched++;
        $display("[TB] FAIL wrap[%0d]: got %h want %h", i, obs, expected());
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, seq_pc());
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b1, 1'b0, seq_pc());
    tick(1'b1, 1'b1, 1'b0, 12'h3A5);
    compared++;
    if (obs !== expected() || fd_valid !== 1'b0 || imem_address !== RESET_PC) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_stall: got %h want %h", obs, expected());
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b0, seq_pc());
      compared++;
      if (obs !== expected()) begin
        mismatched++;
        $display("[TB] FAIL reset_resume[%0d]: got %h want %h", i, obs, expected());
      end
    end
  endtask

  task automatic test_random();
    logic        r, s, f;
    logic [11:0] np;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom % 50) == 0;
      s  = ($urandom % 4) == 0;
      f  = ($urandom % 10) == 0;
      np = (f || ($urandom % 8) == 0) ? 12'($urandom % 4096) : seq_pc();
      tick(r, s, f, np);
      compared++;
      if (obs !== expected()) begin
        mismatched++;
        $display("[TB] FAIL random[%0d] r=%0b s=%0b f=%0b: got %h want %h", i, r, s, f, obs, expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_flush();
    test_stall_flush();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
